hilo_muldiv: RTL and testbench
==============================

HILO_MULDIV -- requirements
Module: hilo_muldiv

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port op_valid, input, 1, qualifies the op strobes this cycle (issuing instruction valid).
REQ-004 SHALL have ports is_mult, is_multu, is_div, is_divu, input, 1 each, op strobes from the decoder.
REQ-005 SHALL have ports hi_wen, lo_wen, input, 1 each, mthi/mtlo strobes.
REQ-006 SHALL have ports src_a, src_b, input, 32 each, rs data and rt data.
REQ-007 SHALL have port cancel, input, 1, aborts the in-flight operation (exception flush).
REQ-008 SHALL have port busy, output, 1, operation in flight; the pipeline stalls mfhi/mflo and new HI/LO ops while high.
REQ-009 SHALL have ports hi, lo, output, 32 each, architectural HI/LO registers for mfhi/mflo.

Function
REQ-010 SHALL accept an op when op_valid & ~busy & (any strobe); strobes while busy are ignored.
REQ-011 SHALL resolve multiple strobes by priority div > divu > mult > multu > hi_wen > lo_wen.
REQ-012 SHALL write mthi/mtlo src_a to HI/LO at the end of the accept cycle; busy is never raised.
REQ-013 SHALL use states IDLE, MUL, DIV; busy = (state != IDLE); IDLE->DIV on div/divu accept, IDLE->MUL on iterative mult accept.
REQ-014 SHALL run division as radix-2 restoring on magnitudes, one quotient bit per cycle, 6-bit counter 0..31; DIV occupies 32 cycles (accept at N, busy N+1..N+32, HI/LO valid from N+33).
REQ-015 SHALL sign-fix signed division: quotient negated iff sign(a) xor sign(b), remainder takes sign(a).
REQ-016 SHALL produce LO=0xFFFFFFFF, HI=src_a for divide-by-zero (signed or unsigned), no exception.
REQ-017 SHALL produce LO=0x80000000, HI=0 for signed 0x80000000 / 0xFFFFFFFF.
REQ-018 SHALL form multiplication as the full 64-bit product (signed or unsigned per op), HI=[63:32], LO=[31:0].
REQ-019 SHALL latch src_a/src_b at accept; operand changes during busy have no effect.
REQ-020 SHALL on cancel in MUL/DIV return to IDLE next cycle with HI/LO unchanged; cancel in the final iteration cycle suppresses the write; cancel in IDLE is ignored, and cancel concurrent with an accept suppresses the accept.

Reset
REQ-021 SHALL on reset set state=IDLE, counter=0, busy=0, hi=0, lo=0, overriding any in-flight op or same-cycle strobe.

Configuration
REQ-022 SHALL honour macro MULDIV_SINGLE_CYCLE_MULT_EN: defined -> mult/multu write HI/LO at end of accept cycle, busy stays 0, MUL state unused; undefined -> iterative shift-add, 32 cycles in MUL with timing identical to REQ-014.

Structure
REQ-023 SHALL place state encodings, iteration count (32) and op-priority encoding in shared package muldiv_pkg.
REQ-024 SHALL implement the restoring divide datapath as sub-module div_iter (magnitudes in, quotient/remainder out, one bit per step); control FSM and HI/LO stay in hilo_muldiv.

Verification
REQ-025 SHALL test divu 100/7 -> busy high exactly 32 cycles, then LO=14, HI=2.
REQ-026 SHALL test div 0xFFFFFFF9/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-027 SHALL test divu 5/0 -> LO=0xFFFFFFFF, HI=5.
REQ-028 SHALL test mult 0xFFFFFFFF*2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same -> HI=1, LO=0xFFFFFFFE; latency 1 cycle with macro, 33 without.
REQ-029 SHALL test div started with HI=0xAAAA, cancel at busy cycle 10 -> busy low next cycle, HI=0xAAAA; then mthi 0x1234 -> HI=0x1234, LO unchanged.
REQ-030 SHALL test reset asserted mid-division -> busy=0, hi=lo=0 next cycle; mult strobe during busy -> ignored, HI/LO reflect only the division.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit.
//   - FSM state encodings (IDLE/MUL/DIV)
//   - iteration count of the multi-cycle datapaths (32 steps, counter 0..31)
//   - op-strobe priority encoding (div > divu > mult > multu > mthi > mtlo)
//   - magnitude helper used to feed the unsigned iterative datapaths
package muldiv_pkg;

  localparam int unsigned ITER_COUNT = 32;
  localparam logic [5:0]  ITER_LAST  = 6'(ITER_COUNT - 1);

  localparam logic [1:0] IDLE_ENC = 2'd0;
  localparam logic [1:0] MUL_ENC  = 2'd1;
  localparam logic [1:0] DIV_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE_ENC,
    ST_MUL  = MUL_ENC,
    ST_DIV  = DIV_ENC
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_DIV   = 3'd1,
    OP_DIVU  = 3'd2,
    OP_MULT  = 3'd3,
    OP_MULTU = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } op_t;

  // Highest-priority strobe wins when the decoder raises several at once.
  function automatic op_t op_select(input logic is_div, input logic is_divu,
                                    input logic is_mult, input logic is_multu,
                                    input logic hi_wen, input logic lo_wen);
    op_t sel;
    if (is_div)        sel = OP_DIV;
    else if (is_divu)  sel = OP_DIVU;
    else if (is_mult)  sel = OP_MULT;
    else if (is_multu) sel = OP_MULTU;
    else if (hi_wen)   sel = OP_MTHI;
    else if (lo_wen)   sel = OP_MTLO;
    else               sel = OP_NONE;
    return sel;
  endfunction

  // Absolute value when treated as signed; 0x80000000 maps to 2^31 unsigned.
  function automatic logic [31:0] magnitude(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/hilo_muldiv_div_iter.sv
// div_iter: radix-2 restoring divider on unsigned magnitudes.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   load               - capture dividend/divisor and clear the partial remainder
//   step               - perform one quotient-bit iteration
//   dividend, divisor  - 32-bit unsigned magnitudes
//   quotient, remainder- result *after* the current step (combinational), so the
//                        controller can commit the final step in the same cycle
module div_iter
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dsr_q;
  logic [32:0] partial;
  logic [32:0] trial;
  logic        fits;

  // Dividend bits shift out of quo_q into the remainder while quotient bits
  // shift in from the bottom, so one register serves both roles.
  always_comb begin
    partial   = {rem_q, quo_q[31]};
    trial     = partial - {1'b0, dsr_q};
    fits      = ~trial[32];
    remainder = fits ? trial[31:0] : partial[31:0];
    quotient  = {quo_q[30:0], fits};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (step) begin
      rem_q <= remainder;
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: MIPS-style HI/LO register unit with mult/multu/div/divu/mthi/mtlo.
// Ports:
//   clk, reset                        - clock, synchronous active-high reset
//   op_valid                          - qualifies the op strobes this cycle
//   is_mult/is_multu/is_div/is_divu   - arithmetic op strobes
//   hi_wen, lo_wen                    - mthi / mtlo strobes (write src_a)
//   src_a, src_b                      - rs / rt operands, latched at accept
//   cancel                            - aborts the in-flight op (flush)
//   busy                              - multi-cycle op in flight
//   hi, lo                            - architectural HI/LO registers
// Configuration macro: MULDIV_SINGLE_CYCLE_MULT_EN -- when defined, mult/multu
// complete in the accept cycle; otherwise they iterate 32 cycles in MUL.
module hilo_muldiv
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        is_mult,
  input  logic        is_multu,
  input  logic        is_div,
  input  logic        is_divu,
  input  logic        hi_wen,
  input  logic        lo_wen,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        cancel,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t      state;
  logic [5:0]  count;
  op_t         op;
  logic        accept;
  logic        last;

  logic        neg_q;
  logic        neg_r;
  logic        div_zero;
  logic [31:0] a_hold;
  logic        div_load;
  logic        div_step;
  logic [31:0] div_quo;
  logic [31:0] div_rem;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  always_comb begin
    sprod = $signed(src_a) * $signed(src_b);
    uprod = {32'd0, src_a} * {32'd0, src_b};
  end
`else
  logic [31:0] mcand;
  logic [63:0] prod;
  logic        neg_p;
  logic [31:0] addend;
  logic [32:0] sum;
  logic [63:0] prod_next;
  logic [63:0] prod_fix;

  // Shift-add: the multiplier sits in prod[31:0] and is consumed LSB first
  // while the accumulating upper half shifts down into its place.
  always_comb begin
    addend    = prod[0] ? mcand : '0;
    sum       = {1'b0, prod[63:32]} + {1'b0, addend};
    prod_next = {sum, prod[31:1]};
    prod_fix  = neg_p ? (64'd0 - prod_next) : prod_next;
  end
`endif

  always_comb begin
    op       = op_select(is_div, is_divu, is_mult, is_multu, hi_wen, lo_wen);
    busy     = (state != ST_IDLE);
    accept   = op_valid && !busy && !cancel && (op != OP_NONE);
    last     = (count == ITER_LAST);
    div_load = accept && ((op == OP_DIV) || (op == OP_DIVU));
    div_step = (state == ST_DIV);
    q_fix    = neg_q ? (32'd0 - div_quo) : div_quo;
    r_fix    = neg_r ? (32'd0 - div_rem) : div_rem;
  end

  div_iter u_div_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (div_load),
    .step      (div_step),
    .dividend  (magnitude(src_a, op == OP_DIV)),
    .divisor   (magnitude(src_b, op == OP_DIV)),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      a_hold   <= '0;
`ifndef MULDIV_SINGLE_CYCLE_MULT_EN
      mcand    <= '0;
      prod     <= '0;
      neg_p    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op)
              OP_DIV, OP_DIVU: begin
                state    <= ST_DIV;
                count    <= '0;
                neg_q    <= (op == OP_DIV) && (src_a[31] ^ src_b[31]);
                neg_r    <= (op == OP_DIV) && src_a[31];
                div_zero <= (src_b == '0);
                a_hold   <= src_a;
              end
`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
              OP_MULT: begin
                hi <= sprod[63:32];
                lo <= sprod[31:0];
              end
              OP_MULTU: begin
                hi <= uprod[63:32];
                lo <= uprod[31:0];
              end
`else
              OP_MULT, OP_MULTU: begin
                state <= ST_MUL;
                count <= '0;
                mcand <= magnitude(src_a, op == OP_MULT);
                prod  <= {32'd0, magnitude(src_b, op == OP_MULT)};
                neg_p <= (op == OP_MULT) && (src_a[31] ^ src_b[31]);
              end
`endif
              OP_MTHI: hi <= src_a;
              OP_MTLO: lo <= src_a;
              default: ;
            endcase
          end
        end
        ST_DIV: begin
          if (cancel) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (last) begin
            state <= ST_IDLE;
            count <= '0;
            // Divide-by-zero bypasses the sign fix-up so signed and unsigned agree.
            if (div_zero) begin
              lo <= '1;
              hi <= a_hold;
            end else begin
              lo <= q_fix;
              hi <= r_fix;
            end
          end else begin
            count <= count + 6'd1;
          end
        end
`ifndef MULDIV_SINGLE_CYCLE_MULT_EN
        ST_MUL: begin
          if (cancel) begin
            state <= ST_IDLE;
            count <= '0;
          end else if (last) begin
            state <= ST_IDLE;
            count <= '0;
            hi    <= prod_fix[63:32];
            lo    <= prod_fix[31:0];
          end else begin
            prod  <= prod_next;
            count <= count + 6'd1;
          end
        end
`endif
        default: begin
          state <= ST_IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        is_mult, is_multu, is_div, is_divu;
  logic        hi_wen, lo_wen;
  logic [31:0] src_a, src_b;
  logic        cancel;
  logic        busy;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;
  int n;

  localparam int K_DIV = 0, K_DIVU = 1, K_MULT = 2, K_MULTU = 3, K_MTHI = 4, K_MTLO = 5;

`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
  localparam int MULT_BUSY = 0;
`else
  localparam int MULT_BUSY = 32;
`endif

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk      (clk),
    .reset    (reset),
    .op_valid (op_valid),
    .is_mult  (is_mult),
    .is_multu (is_multu),
    .is_div   (is_div),
    .is_divu  (is_divu),
    .hi_wen   (hi_wen),
    .lo_wen   (lo_wen),
    .src_a    (src_a),
    .src_b    (src_b),
    .cancel   (cancel),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    op_valid = 1'b0;
    is_mult = 1'b0; is_multu = 1'b0; is_div = 1'b0; is_divu = 1'b0;
    hi_wen = 1'b0; lo_wen = 1'b0;
  endtask

  // Drive one op through its accept edge, then scramble operands to show latching.
  task automatic do_op(input int kind, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1;
    is_div   = (kind == K_DIV);
    is_divu  = (kind == K_DIVU);
    is_mult  = (kind == K_MULT);
    is_multu = (kind == K_MULTU);
    hi_wen   = (kind == K_MTHI);
    lo_wen   = (kind == K_MTLO);
    src_a = a;
    src_b = b;
    tick();
    clear_strobes();
    src_a = 32'hDEAD_BEEF;
    src_b = 32'h0BAD_F00D;
  endtask

  // Counts busy cycles; bounded so a stuck busy still ends the run.
  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    cancel = 1'b0;
    clear_strobes();
    src_a = '0;
    src_b = '0;
    tick();
    tick();
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    reset = 1'b0;

    // divu 100/7
    do_op(K_DIVU, 32'd100, 32'd7);
    check("divu_busy_after_accept", 32'(busy), 32'd1);
    wait_idle(n);
    check("divu_busy_cycles", 32'(n), 32'd32);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);

    // signed -7/2
    do_op(K_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    check("div_neg_lo", lo, 32'hFFFF_FFFD);
    check("div_neg_hi", hi, 32'hFFFF_FFFF);

    // signed overflow
    do_op(K_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    check("div_ovf_lo", lo, 32'h8000_0000);
    check("div_ovf_hi", hi, 32'h0000_0000);

    // divide by zero, unsigned and signed
    do_op(K_DIVU, 32'd5, 32'd0);
    wait_idle(n);
    check("divu_zero_lo", lo, 32'hFFFF_FFFF);
    check("divu_zero_hi", hi, 32'd5);
    do_op(K_DIV, 32'hFFFF_FFF9, 32'd0);
    wait_idle(n);
    check("div_zero_lo", lo, 32'hFFFF_FFFF);
    check("div_zero_hi", hi, 32'hFFFF_FFF9);

    // multiplication
    do_op(K_MULT, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("mult_busy_cycles", 32'(n), 32'(MULT_BUSY));
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    do_op(K_MULTU, 32'hFFFF_FFFF, 32'd2);
    wait_idle(n);
    check("multu_busy_cycles", 32'(n), 32'(MULT_BUSY));
    check("multu_hi", hi, 32'd1);
    check("multu_lo", lo, 32'hFFFF_FFFE);

    // priority: div beats mult; mthi beats mtlo
    op_valid = 1'b1; is_div = 1'b1; is_mult = 1'b1;
    src_a = 32'd20; src_b = 32'd6;
    tick();
    clear_strobes();
    wait_idle(n);
    check("prio_div_cycles", 32'(n), 32'd32);
    check("prio_div_lo", lo, 32'd3);
    check("prio_div_hi", hi, 32'd2);
    do_op(K_MTLO, 32'h55, 32'd0);
    check("mtlo_busy", 32'(busy), 32'd0);
    check("mtlo_lo", lo, 32'h55);
    op_valid = 1'b1; hi_wen = 1'b1; lo_wen = 1'b1; src_a = 32'h77;
    tick();
    clear_strobes();
    check("prio_mthi_hi", hi, 32'h77);
    check("prio_mthi_lo", lo, 32'h55);

    // strobe without op_valid is ignored
    hi_wen = 1'b1; src_a = 32'h9999;
    tick();
    clear_strobes();
    check("novalid_hi", hi, 32'h77);

    // cancel at busy cycle 10
    do_op(K_MTHI, 32'hAAAA, 32'd0);
    do_op(K_DIV, 32'd100, 32'd7);
    repeat (9) tick();
    check("cancel_busy_before", 32'(busy), 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy", 32'(busy), 32'd0);
    check("cancel_hi", hi, 32'hAAAA);
    check("cancel_lo", lo, 32'h55);
    do_op(K_MTHI, 32'h1234, 32'd0);
    check("mthi_hi", hi, 32'h1234);
    check("mthi_lo", lo, 32'h55);

    // cancel concurrent with accept
    cancel = 1'b1;
    do_op(K_MTLO, 32'h99, 32'd0);
    check("cancel_accept_mtlo", lo, 32'h55);
    do_op(K_DIVU, 32'd100, 32'd7);
    cancel = 1'b0;
    check("cancel_accept_div_busy", 32'(busy), 32'd0);

    // cancel in the final iteration cycle suppresses the write
    do_op(K_DIVU, 32'd100, 32'd7);
    repeat (31) tick();
    check("final_busy_before", 32'(busy), 32'd1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("final_cancel_busy", 32'(busy), 32'd0);
    check("final_cancel_hi", hi, 32'h1234);
    check("final_cancel_lo", lo, 32'h55);

    // reset mid-division
    do_op(K_DIVU, 32'd100, 32'd7);
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_hi", hi, 32'd0);
    check("midreset_lo", lo, 32'd0);

    // mult strobe while busy is ignored
    do_op(K_DIVU, 32'd100, 32'd7);
    op_valid = 1'b1; is_mult = 1'b1; src_a = 32'd3; src_b = 32'd3;
    tick();
    clear_strobes();
    wait_idle(n);
    check("busy_mult_cycles", 32'(n + 1), 32'd32);
    check("busy_mult_lo", lo, 32'd14);
    check("busy_mult_hi", hi, 32'd2);
    tick();
    check("busy_mult_no_relaunch", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
